// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage integer pipeline.
//
// Holds one EX->MEM entry (plus its HI/LO update), turns the synchronous
// SRAM read word into the load result, and presents the write-back bus and
// the ID forwarding bus combinationally from the held entry.
//
// Ports
//   clk               rising-edge clock
//   resetn            synchronous, active-low reset
//   stall             per-stage stop bits; [3] stops EX, [4] stops MEM
//   ex_to_mem_bus     {sl[3:0], pc[31:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}
//   ex_hilo           {hiwe, lowe, hidata[31:0], lodata[31:0]}
//   data_sram_rdata   SRAM read word, valid in the first cycle an entry sits in MEM
//   mem_to_wb_bus     {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}
//   mem_hilo          registered copy of ex_hilo
//   mem_to_id_bus     {rf_we, rf_waddr[4:0], rf_wdata[31:0]} forwarding path
//   mem_load_misalign current entry is a misaligned LH/LHU/LW
module mem_stage #(
    parameter int EX_TO_MEM_WD = 75,
    parameter int MEM_TO_WB_WD = 70,
    parameter int StallBus     = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [65:0]             ex_hilo,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [65:0]             mem_hilo,
    output logic [37:0]             mem_to_id_bus,
    output logic                    mem_load_misalign
);

    localparam logic [3:0] SL_LW  = 4'b0001;
    localparam logic [3:0] SL_LB  = 4'b0011;
    localparam logic [3:0] SL_LBU = 4'b0100;
    localparam logic [3:0] SL_LH  = 4'b0101;
    localparam logic [3:0] SL_LHU = 4'b0110;

    logic [EX_TO_MEM_WD-1:0] bus_p1;
    logic [65:0]             hilo_p1;
    logic                    fresh_p1;
    logic [31:0]             hold_rdata_p1;

    // Misaligned: halfword on an odd address, or word on a non-word address.
    function automatic logic load_misaligned(input logic [3:0] sl, input logic [1:0] addr);
        logic mis;
        mis = 1'b0;
        case (sl)
            SL_LH, SL_LHU: mis = addr[0];
            SL_LW:         mis = (addr != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte/half lane select with sign or zero extension; non-loads give 0.
    function automatic logic [31:0] load_extract(input logic [3:0] sl, input logic [1:0] addr,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (sl)
            SL_LB:   r = {{24{b[7]}}, b};
            SL_LBU:  r = {24'd0, b};
            SL_LH:   r = {{16{h[15]}}, h};
            SL_LHU:  r = {16'd0, h};
            SL_LW:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // ---- stage boundary: EX -> MEM register ----
    // A bubble counts as fresh too, so the hold register never carries a
    // stale word into a later stalled entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_p1        <= '0;
            hilo_p1       <= '0;
            fresh_p1      <= 1'b0;
            hold_rdata_p1 <= '0;
        end else begin
            if (fresh_p1) begin
                hold_rdata_p1 <= data_sram_rdata;
            end
            if (stall[3] && !stall[4]) begin
                bus_p1   <= '0;
                hilo_p1  <= '0;
                fresh_p1 <= 1'b1;
            end else if (!stall[3]) begin
                bus_p1   <= ex_to_mem_bus;
                hilo_p1  <= ex_hilo;
                fresh_p1 <= 1'b1;
            end else begin
                fresh_p1 <= 1'b0;
            end
        end
    end

    // ---- stage boundary: MEM combinational outputs ----
    logic [3:0]  sl;
    logic [31:0] pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] rdata_sel;
    logic        misalign;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        rf_we_out;
    logic        unused_stall;

    assign sl         = bus_p1[74:71];
    assign pc         = bus_p1[70:39];
    assign sel_rf_res = bus_p1[38];
    assign rf_we      = bus_p1[37];
    assign rf_waddr   = bus_p1[36:32];
    assign ex_result  = bus_p1[31:0];

    // Live SRAM word on the first MEM cycle, the captured copy while stalled.
    assign rdata_sel = fresh_p1 ? data_sram_rdata : hold_rdata_p1;
    assign misalign  = load_misaligned(sl, ex_result[1:0]);
    assign load_data = misalign ? 32'd0 : load_extract(sl, ex_result[1:0], rdata_sel);
    assign rf_wdata  = sel_rf_res ? load_data : ex_result;
    assign rf_we_out = rf_we && (rf_waddr != 5'd0);

    assign mem_to_wb_bus     = {pc, rf_we_out, rf_waddr, rf_wdata};
    assign mem_to_id_bus     = {rf_we_out, rf_waddr, rf_wdata};
    assign mem_load_misalign = misalign;
    assign mem_hilo          = hilo_p1;

    assign unused_stall = ^{stall[StallBus-1:5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage load extraction, misalignment,
// stall hold, bubble insertion, r0 write suppression and reset behaviour.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic [5:0]   stall;
    logic [74:0]  ex_to_mem_bus;
    logic [65:0]  ex_hilo;
    logic [31:0]  data_sram_rdata;
    logic [69:0]  mem_to_wb_bus;
    logic [65:0]  mem_hilo;
    logic [37:0]  mem_to_id_bus;
    logic         mem_load_misalign;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .stall             (stall),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .ex_hilo           (ex_hilo),
        .data_sram_rdata   (data_sram_rdata),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_hilo          (mem_hilo),
        .mem_to_id_bus     (mem_to_id_bus),
        .mem_load_misalign (mem_load_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [74:0] mk_ex(input logic [3:0] sl, input logic [31:0] pc,
                                          input logic sel, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] res);
        return {sl, pc, sel, we, waddr, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load an entry with stall=0, then present the SRAM word for that cycle.
    task automatic load_entry(input logic [74:0] bus, input logic [31:0] rdata);
        stall = 6'd0;
        ex_to_mem_bus = bus;
        tick();
        data_sram_rdata = rdata;
        #1;
    endtask

    initial begin
        resetn          = 1'b0;
        stall           = 6'b011000;
        ex_to_mem_bus   = mk_ex(4'b0001, 32'hAAAA_0000, 1'b1, 1'b1, 5'd7, 32'h0000_0010);
        ex_hilo         = {2'b11, 32'h5555_5555, 32'h6666_6666};
        data_sram_rdata = 32'h1234_5678;

        // Reset overrides stall and clears everything
        tick();
        tick();
        check("rst_wb",   mem_to_wb_bus, 70'd0);
        check("rst_id",   {32'd0, mem_to_id_bus}, 70'd0);
        check("rst_mis",  {69'd0, mem_load_misalign}, 70'd0);
        check("rst_hilo", {4'd0, mem_hilo}, 70'd0);

        // First cycle after reset release with idle inputs
        resetn = 1'b1;
        stall = 6'd0;
        ex_to_mem_bus = '0;
        ex_hilo = '0;
        tick();
        check("post_rst_wb", mem_to_wb_bus, 70'd0);

        // LB at addr 2: byte 0xFF sign-extends
        ex_hilo = {2'b10, 32'h1111_2222, 32'h3333_4444};
        load_entry(mk_ex(4'b0011, 32'h0000_0100, 1'b1, 1'b1, 5'd5, 32'h0000_1002), 32'h80FF_1234);
        check("lb_wb", mem_to_wb_bus, {32'h0000_0100, 1'b1, 5'd5, 32'hFFFF_FFFF});
        check("lb_id", {32'd0, mem_to_id_bus}, {32'd0, 1'b1, 5'd5, 32'hFFFF_FFFF});
        check("lb_hilo", {4'd0, mem_hilo}, {4'd0, 2'b10, 32'h1111_2222, 32'h3333_4444});

        // LBU at addr 2: zero-extends
        load_entry(mk_ex(4'b0100, 32'h0000_0104, 1'b1, 1'b1, 5'd6, 32'h0000_1002), 32'h80FF_1234);
        check("lbu_wdata", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h0000_00FF});

        // LH at addr 2: upper half 0x8001 sign-extends
        load_entry(mk_ex(4'b0101, 32'h0000_0108, 1'b1, 1'b1, 5'd6, 32'h0000_2002), 32'h8001_7FFF);
        check("lh_wdata", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hFFFF_8001});
        check("lh_mis", {69'd0, mem_load_misalign}, 70'd0);

        // LHU at addr 0: lower half zero-extended
        load_entry(mk_ex(4'b0110, 32'h0000_010C, 1'b1, 1'b1, 5'd6, 32'h0000_2000), 32'h8001_7FFF);
        check("lhu_wdata", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h0000_7FFF});

        // LH at odd address is misaligned
        load_entry(mk_ex(4'b0101, 32'h0000_0110, 1'b1, 1'b1, 5'd6, 32'h0000_2003), 32'h8001_7FFF);
        check("lh_odd_mis", {69'd0, mem_load_misalign}, {69'd0, 1'b1});
        check("lh_odd_wdata", {38'd0, mem_to_wb_bus[31:0]}, 70'd0);

        // LW at addr 1: misaligned, data zero
        load_entry(mk_ex(4'b0001, 32'h0000_0114, 1'b1, 1'b1, 5'd8, 32'h0000_3001), 32'hCAFE_F00D);
        check("lw_mis", {69'd0, mem_load_misalign}, {69'd0, 1'b1});
        check("lw_mis_wdata", {38'd0, mem_to_wb_bus[31:0]}, 70'd0);

        // LW at addr 0: aligned full word
        load_entry(mk_ex(4'b0001, 32'h0000_0118, 1'b1, 1'b1, 5'd8, 32'h0000_3000), 32'hCAFE_F00D);
        check("lw_ok_mis", {69'd0, mem_load_misalign}, 70'd0);
        check("lw_ok_wb", mem_to_wb_bus, {32'h0000_0118, 1'b1, 5'd8, 32'hCAFE_F00D});

        // Load, then a 3-cycle MEM stall while the SRAM word goes to zero
        ex_hilo = {2'b11, 32'h7777_8888, 32'h9999_AAAA};
        load_entry(mk_ex(4'b0001, 32'h0000_0200, 1'b1, 1'b1, 5'd9, 32'h0000_4000), 32'hDEAD_BEEF);
        check("stall_c0", mem_to_wb_bus, {32'h0000_0200, 1'b1, 5'd9, 32'hDEAD_BEEF});
        stall = 6'b011000;
        ex_to_mem_bus = mk_ex(4'b0011, 32'h0000_0300, 1'b1, 1'b1, 5'd3, 32'h0000_0001);
        ex_hilo = '0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            data_sram_rdata = 32'h0000_0000;
            #1;
            check($sformatf("stall_c%0d", i), mem_to_wb_bus,
                  {32'h0000_0200, 1'b1, 5'd9, 32'hDEAD_BEEF});
        end
        check("stall_hilo", {4'd0, mem_hilo}, {4'd0, 2'b11, 32'h7777_8888, 32'h9999_AAAA});

        // EX stopped, MEM free: bubble
        stall = 6'b001000;
        tick();
        check("bubble_wb", mem_to_wb_bus, 70'd0);
        check("bubble_hilo", {4'd0, mem_hilo}, 70'd0);

        // ALU result aimed at r0: write enable suppressed
        load_entry(mk_ex(4'b0000, 32'h0000_0400, 1'b0, 1'b1, 5'd0, 32'h0000_1234), 32'hFFFF_FFFF);
        check("r0_wb", mem_to_wb_bus, {32'h0000_0400, 1'b0, 5'd0, 32'h0000_1234});

        // Store with no upstream write enable passes through as-is
        load_entry(mk_ex(4'b0010, 32'h0000_0404, 1'b0, 1'b0, 5'd4, 32'h0000_5001), 32'hFFFF_FFFF);
        check("sw_wb", mem_to_wb_bus, {32'h0000_0404, 1'b0, 5'd4, 32'h0000_5001});
        check("sw_mis", {69'd0, mem_load_misalign}, 70'd0);

        // Reset in the middle of a load discards it
        ex_hilo = {2'b01, 32'h1234_0000, 32'h0000_5678};
        load_entry(mk_ex(4'b0011, 32'h0000_0500, 1'b1, 1'b1, 5'd10, 32'h0000_6000), 32'h0000_0080);
        check("pre_rst_wb", mem_to_wb_bus, {32'h0000_0500, 1'b1, 5'd10, 32'hFFFF_FF80});
        resetn = 1'b0;
        tick();
        check("midrst_wb", mem_to_wb_bus, 70'd0);
        check("midrst_id", {32'd0, mem_to_id_bus}, 70'd0);
        check("midrst_hilo", {4'd0, mem_hilo}, 70'd0);
        check("midrst_mis", {69'd0, mem_load_misalign}, 70'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
